// File: rtl/dc_offset_pkg.sv
// Shared types and helpers for the DC offset tracker.
//   dc_state_e : controller state encoding as seen on the state output port
//   sat_signed : clip a signed value to the signed range of a given width
package dc_offset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_HOLD    = 2'd3
  } dc_state_e;

  // Carrier width for sat_signed; every caller sign-extends into it.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int                      width
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v)      return max_v;
    else if (value < min_v) return min_v;
    else                    return value;
  endfunction

endpackage

// File: rtl/dc_offset_integrator.sv
// Leaky first-order integrator holding the DC estimate.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : force the accumulator to zero (controller idle)
//   upd        : integrate in_data on this edge
//   fast       : use acquisition gain (only with DC_OFFSET_TRACKER_ACQUIRE_EN)
//   in_data    : signed sample
//   est        : floor(acc / 2^ALPHA_SHIFT), the current mean estimate
// Optional feature macro: DC_OFFSET_TRACKER_ACQUIRE_EN (fast-gain path).
module dc_offset_integrator
  import dc_offset_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ALPHA_SHIFT = 20
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
  ,
  parameter int FAST_SHIFT  = 8
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    upd,
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
  input  logic                    fast,
`endif
  input  logic signed [WIDTH-1:0] in_data,
  output logic signed [WIDTH-1:0] est
);

  localparam int A  = WIDTH + ALPHA_SHIFT;
  localparam int AX = A + 1;

  logic signed [A-1:0]  acc_p0;
  logic signed [A-1:0]  acc_d;
  logic signed [AX-1:0] in_x;
  logic signed [AX-1:0] est_x;
  logic signed [AX-1:0] sum_x;

  // Upper WIDTH bits of a two's complement value are its floor division.
  assign est = $signed(acc_p0[A-1:ALPHA_SHIFT]);

  always_comb begin
    in_x  = AX'(in_data);
    est_x = AX'(est);
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
    // Both terms scaled so the effective loop gain becomes 2^-FAST_SHIFT.
    if (fast) begin
      in_x  = in_x <<< (ALPHA_SHIFT - FAST_SHIFT);
      est_x = est_x <<< (ALPHA_SHIFT - FAST_SHIFT);
    end
`endif
    sum_x = AX'(acc_p0) + in_x - est_x;
    acc_d = acc_p0;
    if (clr)      acc_d = '0;
    else if (upd) acc_d = A'(sat_signed(SAT_W'(sum_x), A));
  end

  // Stage p0: accumulator update on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_p0 <= '0;
    else       acc_p0 <= acc_d;
  end

endmodule

// File: rtl/dc_offset_tracker.sv
// Receive-path DC offset estimator producing the negated, saturated estimate
// that feeds the second operand of the downstream saturating adder.
//   clk, reset : clock, asynchronous active-high reset
//   en         : tracking enable (level); low forces IDLE and clears estimate
//   freeze     : hold the current estimate (level)
//   in_data    : signed sample, qualified by in_valid (no backpressure)
//   out_corr   : sat(-estimate), strobed by out_valid when recomputed
//   state      : IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3
// Optional feature macro: DC_OFFSET_TRACKER_ACQUIRE_EN builds the ACQUIRE
// state, its settle counter and the fast-gain integrator path.
module dc_offset_tracker
  import dc_offset_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ALPHA_SHIFT   = 20,
  parameter int FAST_SHIFT    = 8,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    freeze,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic signed [WIDTH-1:0] out_corr,
  output logic                    out_valid,
  output logic [1:0]              state
);

  function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] v);
    return WIDTH'(sat_signed(-(SAT_W'(v)), WIDTH));
  endfunction

  dc_state_e state_q, state_d;
  logic      accept;
  logic      clr;
  logic      vld_p0;
  logic      vld_p1;
  logic      vld_d;
  logic signed [WIDTH-1:0] est;
  logic signed [WIDTH-1:0] corr_p1;
  logic signed [WIDTH-1:0] corr_d;

`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             fast;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    clr     = 1'b0;
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
    settle_d = settle_q;
    fast     = 1'b0;
`endif
    if (!en) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
      settle_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          clr = 1'b1;
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
          settle_d = '0;
          state_d  = ST_ACQUIRE;
`else
          state_d  = ST_TRACK;
`endif
        end
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
        ST_ACQUIRE: begin
          // Leaving for HOLD drops any sample on this edge and the count.
          if (freeze) begin
            state_d  = ST_HOLD;
            settle_d = '0;
          end else if (in_valid) begin
            accept = 1'b1;
            fast   = 1'b1;
            if (settle_q == CNT_W'(SETTLE_CYCLES - 1)) begin
              state_d  = ST_TRACK;
              settle_d = '0;
            end else begin
              settle_d = settle_q + 1'b1;
            end
          end
        end
`endif
        ST_TRACK: begin
          if (freeze) state_d = ST_HOLD;
          else        accept  = in_valid;
        end
        ST_HOLD: begin
          if (!freeze) state_d = ST_TRACK;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    corr_d = corr_p1;
    vld_d  = 1'b0;
    // Entering or sitting in IDLE zeroes the correction silently.
    if (clr) begin
      corr_d = '0;
    end else if (vld_p0) begin
      corr_d = neg_sat(est);
      vld_d  = 1'b1;
    end
  end

  dc_offset_integrator #(
    .WIDTH       (WIDTH),
    .ALPHA_SHIFT (ALPHA_SHIFT)
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
    ,
    .FAST_SHIFT  (FAST_SHIFT)
`endif
  ) u_integrator (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .upd     (accept),
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
    .fast    (fast),
`endif
    .in_data (in_data),
    .est     (est)
  );

  // Stage p0: controller state and accept flag (acc updates in the integrator)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vld_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p0  <= accept;
    end
  end

`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) settle_q <= '0;
    else       settle_q <= settle_d;
  end
`endif

  // Stage p1: correction output from the updated estimate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corr_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      corr_p1 <= corr_d;
      vld_p1  <= vld_d;
    end
  end

  assign out_corr  = corr_p1;
  assign out_valid = vld_p1;
  assign state     = state_q;

endmodule

// File: tb/tb_dc_offset_tracker.sv
module tb_dc_offset_tracker;

  localparam int WIDTH         = 16;
  localparam int ALPHA_SHIFT   = 4;
  localparam int FAST_SHIFT    = 2;
  localparam int SETTLE_CYCLES = 8;
  localparam int A             = WIDTH + ALPHA_SHIFT;
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
  localparam int FIRST_ST = 1;
`else
  localparam int FIRST_ST = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic freeze;
  logic in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic signed [WIDTH-1:0] out_corr;
  logic out_valid;
  logic [1:0] state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: estimate as a plain integer, mode as an int.
  longint m_acc, m_corr;
  int     m_vld, m_state, m_settle, m_pend;

  always #5 clk = ~clk;

  dc_offset_tracker #(
    .WIDTH         (WIDTH),
    .ALPHA_SHIFT   (ALPHA_SHIFT),
    .FAST_SHIFT    (FAST_SHIFT),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .freeze    (freeze),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_corr  (out_corr),
    .out_valid (out_valid),
    .state     (state)
  );

  task automatic check(input string tag, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clip(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_corr = 0; m_vld = 0; m_state = 0; m_settle = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    longint est, g, nacc, ncorr;
    int nvld, npend, nstate, nsettle;
    est     = floor_div(m_acc, longint'(1) << ALPHA_SHIFT);
    nacc    = m_acc;
    ncorr   = m_corr;
    nvld    = 0;
    npend   = 0;
    nstate  = m_state;
    nsettle = m_settle;
    if (!en || m_state == 0) begin
      nacc = 0; ncorr = 0; nsettle = 0;
      nstate = en ? FIRST_ST : 0;
    end else begin
      if (m_pend != 0) begin
        ncorr = clip(-est, WIDTH);
        nvld  = 1;
      end
      if (m_state == 3) begin
        if (!freeze) nstate = 2;
      end else if (freeze) begin
        nstate = 3; nsettle = 0;
      end else if (in_valid) begin
        g = (m_state == 1) ? (longint'(1) << (ALPHA_SHIFT - FAST_SHIFT)) : 1;
        nacc  = clip(m_acc + g * longint'(in_data) - g * est, A);
        npend = 1;
        if (m_state == 1) begin
          nsettle = m_settle + 1;
          if (nsettle == SETTLE_CYCLES) begin nstate = 2; nsettle = 0; end
        end
      end
    end
    m_acc = nacc; m_corr = ncorr; m_vld = nvld; m_pend = npend;
    m_state = nstate; m_settle = nsettle;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("corr", out_corr, m_corr);
    check("vld", out_valid, m_vld);
    check("state", state, m_state);
  endtask

  task automatic run(input int n, input int d, input int v);
    for (int i = 0; i < n; i++) begin
      in_data  = WIDTH'(d);
      in_valid = v[0];
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acq_seen;
    int r;
    reset = 1'b1; en = 1'b0; freeze = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    #12;
    check("rst_corr", out_corr, 0);
    check("rst_vld", out_valid, 0);
    check("rst_state", state, 0);
    reset = 1'b0;

    // Constant 1000, continuous valid: settles to -1000.
    en = 1'b1;
    run(1, 1000, 1);
    check("first_state", state, FIRST_ST);
    run(20, 1000, 1);
    check("track_state", state, 2);
    run(300, 1000, 1);
    check("conv_1000", out_corr, -1000);
    check("conv_vld", out_valid, 1);

    // Freeze with a new level applied: estimate holds.
    freeze = 1'b1;
    run(20, -5000, 1);
    check("hold_corr", out_corr, -1000);
    check("hold_state", state, 3);
    freeze = 1'b0;
    run(1, -5000, 1);
    check("release_state", state, 2);
    run(60, -5000, 1);
    check("moves_toward", (out_corr > -1000) ? 1 : 0, 1);

    // Enable drop: immediate IDLE, zero correction, no strobe.
    en = 1'b0;
    run(1, -5000, 1);
    check("idle_state", state, 0);
    check("idle_corr", out_corr, 0);
    check("idle_vld", out_valid, 0);

    // Re-enable with in_valid toggling 1-0-1.
    en = 1'b1;
    acq_seen = 0;
    for (int i = 0; i < 40; i++) begin
      in_data  = WIDTH'(1000);
      in_valid = (i % 2 == 0);
      if (state == 2'd1 && in_valid) acq_seen++;
      step();
    end
`ifdef DC_OFFSET_TRACKER_ACQUIRE_EN
    check("acq_len", acq_seen, SETTLE_CYCLES);
`endif

    // Converge again, then async reset mid-TRACK.
    run(300, 1000, 1);
    check("pre_rst", out_corr, -1000);
    #2;
    reset = 1'b1;
    #1;
    check("arst_corr", out_corr, 0);
    check("arst_state", state, 0);
    check("arst_vld", out_valid, 0);
    model_reset();
    #2;
    reset = 1'b0;
    run(1, 1000, 1);
    check("post_rst_state", state, FIRST_ST);

    // Full-scale negative input: correction saturates positive.
    run(700, -32768, 1);
    check("sat_pos", out_corr, 32767);
    run(50, -32768, 1);
    check("sat_hold", out_corr, 32767);

    // Randomized mix of data, gaps, freeze and enable drops.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       in_data = WIDTH'(-32768);
      else if (r < 10) in_data = WIDTH'(32767);
      else             in_data = WIDTH'($urandom_range(0, 65535));
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) freeze = ~freeze;
      en = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dc_offset_tracker.md
# dc_offset_tracker

Receive-path DC offset estimator and correction generator. Tracks the mean of a signed sample stream with a leaky first-order integrator and outputs the saturated negated estimate. That output drives the second operand of the downstream saturating two-input adder, so the adder's sum is the offset-corrected sample. One instance is used per I/Q rail; it has no internal delay line and does not pass samples through.

## Interface
- WIDTH, 16: sample width, two's complement.
- ALPHA_SHIFT, 20: tracking loop gain is 2^-ALPHA_SHIFT; integrator width is A = WIDTH+ALPHA_SHIFT.
- FAST_SHIFT, 8: acquisition gain 2^-FAST_SHIFT. Must satisfy 1 ≤ FAST_SHIFT < ALPHA_SHIFT. Used only with the macro.
- SETTLE_CYCLES, 1024: number of valid samples spent in ACQUIRE. Must be ≥1. Used only with the macro.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- en  in  1  tracking enable, level.
- freeze  in  1  hold the current estimate, level.
- in_data  in  WIDTH  signed sample.
- in_valid  in  1  in_data qualifier; no backpressure.
- out_corr  out  WIDTH  signed correction = sat(−estimate).
- out_valid  out  1  one-cycle strobe when out_corr has been recomputed.
- state  out  2  IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3.

## Operation
- Integrator `acc` is signed, A bits wide. `est` = acc[A-1:ALPHA_SHIFT], which is the floor of acc/2^ALPHA_SHIFT.
- Update (TRACK): on each in_valid, acc ← sat_A(acc + sext(in_data) − sext(est)). Intermediates are computed in A+1 bits and then clipped to the signed A-bit range.
- Update (ACQUIRE): same form, with both the in_data and est terms shifted left by ALPHA_SHIFT−FAST_SHIFT before the add.
- out_corr ← −est, computed in WIDTH+1 bits and clipped to WIDTH. An est of −2^(WIDTH−1) gives +2^(WIDTH−1)−1.
- State machine (evaluated every cycle):
  - en=0 forces IDLE from any state. In IDLE, acc ← 0 and out_corr ← 0 in the same edge. en has priority over freeze.
  - IDLE → ACQUIRE when en=1 (macro defined); IDLE → TRACK when en=1 (macro undefined).
  - ACQUIRE → TRACK after SETTLE_CYCLES valid samples have been integrated.
  - ACQUIRE or TRACK → HOLD when freeze=1. Entering HOLD from ACQUIRE discards the settle count.
  - HOLD → TRACK when freeze=0. There is never re-acquisition out of HOLD.
  - In HOLD, acc and out_corr are held and in_valid is ignored.
- A sample is integrated only if it arrives in ACQUIRE or TRACK and the state is not leaving on the same edge. A transition out (en=0 or freeze=1) takes precedence over the sample, and the sample is dropped.

## Timing
- Reset values: acc=0, out_corr=0, out_valid=0, state=IDLE, settle counter=0.
- A sample accepted on edge k updates acc at edge k.
- out_corr reflecting that sample appears at edge k+1, with out_valid=1 for that single cycle. Latency is 2 edges, sample-to-correction.
- Back-to-back in_valid gives one out_valid per cycle, each also at 2-edge latency.
- Gaps in in_valid: acc and out_corr hold; out_valid=0.
- Entering IDLE: out_corr=0 at the same edge, with no out_valid strobe.
- Reset asserted mid-operation clears everything immediately (asynchronously). After deassertion, the first acceptable edge behaves as from IDLE.

## Configuration
- DC_OFFSET_TRACKER_ACQUIRE_EN:
  - Defined: the ACQUIRE state, the settle counter and the fast-gain path are built. Behaviour is as above.
  - Undefined: none of that logic exists, state never reads 1, and FAST_SHIFT/SETTLE_CYCLES are ignored.

## Structure
- Shared package `dc_offset_pkg`:
  - state enum and encodings;
  - function `sat_signed(value, width)` used for both the acc and out_corr clips.
- One sub-module, `dc_offset_integrator`: acc register plus gain select and saturating update. The FSM, settle counter and output register stay in the top.

## Test plan
All scenarios use WIDTH=16, ALPHA_SHIFT=4, FAST_SHIFT=2, SETTLE_CYCLES=8.
- Constant in_data=1000, en=1, continuous valid → state goes 0→1→2; out_corr settles to −1000 (0xFC18) and stays there; out_valid every cycle at 2-edge latency.
- Constant in_data=−32768 → out_corr saturates to +32767; acc never wraps positive.
- Converge to 1000, then freeze=1 and apply in_data=−5000 → out_corr stays −1000 and state=3; on release, state=2 and the estimate moves toward −5000 at TRACK gain.
- in_valid toggling 1-0-1 → acc advances only on valid cycles; ACQUIRE lasts exactly 8 valid samples regardless of the gaps.
- en dropped mid-convergence → same edge: state=0, out_corr=0, no out_valid; a later en=1 re-enters ACQUIRE from acc=0.
- Reset pulse while in TRACK at −1000 → out_corr=0 and state=0 asynchronously; with the macro undefined, state goes 0→2 directly.
